// File: rtl/input_mapper.sv
// Serial-to-parallel input stage for an 8-point FFT: collects 8 complex samples
// into a capture bank in bit-reversed lane order, then hands whole frames to an output bank.
module input_mapper #(
  parameter int width = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [width-1:0]     in_r,
  input  logic [width-1:0]     in_i,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [8*width-1:0]   out_r,
  output logic [8*width-1:0]   out_i
);

  logic [2:0]         wr_idx_q, wr_idx_d;
  logic               cap_full_q, cap_full_d;
  logic               out_vld_q, out_vld_d;
  logic [8*width-1:0] cap_r_q, cap_r_d;
  logic [8*width-1:0] cap_i_q, cap_i_d;
  logic [8*width-1:0] out_r_q, out_r_d;
  logic [8*width-1:0] out_i_q, out_i_d;

  logic       xfer;
  logic       accept;
  logic [2:0] wr_lane;

  // in_rdy is gated by rstn so the block refuses samples while reset is held.
  assign xfer    = cap_full_q && (!out_vld_q || out_rdy);
  assign in_rdy  = rstn && (!cap_full_q || xfer);
  assign accept  = in_vld && in_rdy && !clr;
  assign wr_lane = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2]};

  // A transfer copies the pre-edge capture bank, so a sample accepted in the same
  // cycle lands in lane 0 of the next frame without disturbing the copied data.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    cap_full_d = cap_full_q;
    out_vld_d  = out_vld_q;
    cap_r_d    = cap_r_q;
    cap_i_d    = cap_i_q;
    out_r_d    = out_r_q;
    out_i_d    = out_i_q;

    if (xfer) begin
      out_r_d    = cap_r_q;
      out_i_d    = cap_i_q;
      out_vld_d  = 1'b1;
      cap_full_d = 1'b0;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    if (clr) begin
      wr_idx_d   = 3'd0;
      cap_full_d = 1'b0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_lane == 3'(k)) begin
          cap_r_d[k*width +: width] = in_r;
          cap_i_d[k*width +: width] = in_i;
        end
      end
      wr_idx_d = wr_idx_q + 3'd1;
      if (wr_idx_q == 3'd7) begin
        cap_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx_q   <= '0;
      cap_full_q <= 1'b0;
      out_vld_q  <= 1'b0;
      cap_r_q    <= '0;
      cap_i_q    <= '0;
      out_r_q    <= '0;
      out_i_q    <= '0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      cap_full_q <= cap_full_d;
      out_vld_q  <= out_vld_d;
      cap_r_q    <= cap_r_d;
      cap_i_q    <= cap_i_d;
      out_r_q    <= out_r_d;
      out_i_q    <= out_i_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_r   = out_r_q;
  assign out_i   = out_i_q;

endmodule
